// File: rtl/fpalu_mac_seq.sv
// fpalu_mac_seq: FIR tap MUL/ADD sequencer feeding a fixed-latency FPALU, folding products into an AL accumulator.
// Define FPALU_MAC_ZSKIP_EN to bypass the FPALU for taps with a zero mantissa operand.
module fpalu_mac_seq #(
  parameter int ALU_LAT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [16:0]      in_a,
  input  logic [16:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [28:0]      out_y,
  output logic [28:0]      alu_a,
  output logic [28:0]      alu_b,
  output logic             alu_add_muln,
  output logic             alu_clk_en,
  input  logic [28:0]      alu_y,
  output logic             busy,
  output logic [CNT_W-1:0] tap_cnt
);
  localparam int WW = $clog2(ALU_LAT);
  typedef enum logic [2:0] {IDLE, MUL_ISS, MUL_WAIT, ADD_ISS, ADD_WAIT, OUT} state_t;
  state_t state, state_d;
  logic [WW-1:0] wcnt;
  logic [28:0] acc, prod_n;
  logic acc_vld, last_r, psgn_r;
  logic accept, zero, skip, issue, wdone, mul_done, add_done, first, fold, fin;
  function automatic logic [28:0] pack(input logic [16:0] x);
    return {x[16], 1'b0, x[15:11], 11'b0, x[10:0]};
  endfunction
  assign in_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
`ifdef FPALU_MAC_ZSKIP_EN
  assign zero = in_a[10:0] == '0 || in_b[10:0] == '0;
`else
  assign zero = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = !accept ? IDLE : skip ? (in_last ? OUT : IDLE) : MUL_ISS;
      MUL_ISS:  state_d = MUL_WAIT;
      MUL_WAIT: state_d = !wdone ? MUL_WAIT : acc_vld ? ADD_ISS : last_r ? OUT : IDLE;
      ADD_ISS:  state_d = ADD_WAIT;
      ADD_WAIT: state_d = !wdone ? ADD_WAIT : last_r ? OUT : IDLE;
      OUT:      state_d = out_ready ? IDLE : OUT;
      default:  state_d = IDLE;
    endcase
  end
  // The MUL sign comes from the operand signs, never from alu_y[28].
  always_comb begin
    accept = in_valid & in_ready;
    skip = accept & zero;
    issue = accept & ~zero;
    wdone = wcnt == '0;
    mul_done = state == MUL_WAIT && wdone;
    add_done = state == ADD_WAIT && wdone;
    first = mul_done & ~acc_vld;
    fold = first | add_done | skip;
    fin = fold & (skip ? in_last : last_r);
    prod_n = {psgn_r, alu_y[27:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_add_muln <= 1'b0;
      alu_clk_en <= 1'b0;
      tap_cnt <= '0;
      acc <= '0;
      acc_vld <= 1'b0;
      last_r <= 1'b0;
      psgn_r <= 1'b0;
      wcnt <= '0;
    end else begin
      if (accept) begin
        last_r <= in_last;
        psgn_r <= in_a[16] ^ in_b[16];
      end
      if (issue) begin
        alu_a <= pack(in_a);
        alu_b <= pack(in_b);
        alu_add_muln <= 1'b0;
        alu_clk_en <= 1'b1;
      end
      if (mul_done && acc_vld) begin
        alu_a <= acc;
        alu_b <= prod_n;
        alu_add_muln <= 1'b1;
      end
      if (first || add_done) alu_clk_en <= 1'b0;
      if (first) begin
        acc <= prod_n;
        acc_vld <= 1'b1;
      end
      if (add_done) acc <= alu_y;
      if (state == MUL_ISS || state == ADD_ISS) wcnt <= WW'(ALU_LAT - 1);
      else if (state == MUL_WAIT || state == ADD_WAIT) wcnt <= wcnt - 1'b1;
      if (fold) tap_cnt <= tap_cnt + 1'b1;
      if (fin) begin
        out_valid <= 1'b1;
        out_y <= first ? prod_n : add_done ? alu_y : acc;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        acc <= '0;
        acc_vld <= 1'b0;
        tap_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fpalu_mac_seq.sv
// tb_fpalu_mac_seq: scoreboard bench for fpalu_mac_seq with a fixed-latency FPALU stub.
module tb_fpalu_mac_seq;
  localparam int LAT = 4;
  logic clk = 0, rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic alu_add_muln, alu_clk_en, busy;
  logic [16:0] in_a, in_b;
  logic [28:0] out_y, alu_a, alu_b, alu_y, hold_y;
  logic [7:0] tap_cnt;
  int cyc = 0, n_chk = 0, n_fail = 0, acc_cyc = 0, run = 0, nops = 0;
  logic ov_q, ce_q, am_q, iss;
  typedef struct packed {logic add; logic [28:0] a; logic [28:0] b;} op_t;
  typedef struct {logic [28:0] y; int cnt; int acc; int lat;} out_t;
  op_t opq[$];
  out_t oq[$];
  op_t mo;
  out_t me;
  logic [28:0] pipe [LAT];

  fpalu_mac_seq #(.ALU_LAT(LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_add_muln(alu_add_muln), .alu_clk_en(alu_clk_en),
    .alu_y(alu_y), .busy(busy), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FPALU stub: ADD is an integer sum, MUL returns a deliberately wrong sign bit.
  function automatic logic [28:0] stub(input logic [28:0] a, input logic [28:0] b, input logic add);
    if (add) return a + b;
    if (a == 29'h03C00000 && b == 29'h07800400) return {~(a[28] ^ b[28]), 28'hBE00000};
    return {~(a[28] ^ b[28]), a[27:0] ^ b[27:0]};
  endfunction

  always @(posedge clk)
    if (rst) for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    else if (alu_clk_en) begin
      pipe[0] <= stub(alu_a, alu_b, alu_add_muln);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign alu_y = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic op(input logic add, input logic [28:0] a, input logic [28:0] b);
    opq.push_back({add, a, b});
  endtask

  task automatic expect_out(input logic [28:0] y, input int cnt, input int lat);
    oq.push_back('{y, cnt, acc_cyc, lat});
  endtask

  task automatic send(input logic [16:0] a, input logic [16:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) fail("send_timeout");
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oq.size() != 0 || busy) && n < 500) begin @(negedge clk); n++; end
    chk("idle_timeout", n < 500, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ov_q = 0; ce_q = 0; am_q = 0; run = 0; nops = 0;
    end else begin
      iss = (alu_clk_en && !ce_q) || (alu_add_muln && !am_q);
      if (iss) begin
        if (opq.size() == 0) fail("op_unexpected");
        else begin
          mo = opq.pop_front();
          chk("op_kind", alu_add_muln, mo.add);
          chk("op_a", alu_a, mo.a);
          chk("op_b", alu_b, mo.b);
        end
      end
      if (alu_clk_en) begin
        run++;
        if (iss) nops++;
      end else if (run != 0) begin
        chk("clk_en_run", run, nops * (LAT + 1));
        run = 0; nops = 0;
      end
      if (out_valid && !ov_q) begin
        if (oq.size() == 0) fail("out_unexpected");
        else begin
          me = oq.pop_front();
          chk("out_y", out_y, me.y);
          chk("tap_cnt", tap_cnt, me.cnt);
          chk("latency", cyc - me.acc, me.lat);
        end
        hold_y = out_y;
      end else if (out_valid) chk("out_hold", out_y, hold_y);
      ov_q = out_valid; ce_q = alu_clk_en; am_q = alu_add_muln;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_last = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_add_muln", alu_add_muln, 0);
    chk("rst_clk_en", alu_clk_en, 0);
    chk("rst_tap_cnt", tap_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_clk_en", alu_clk_en, 0);
      chk("idle_out_valid", out_valid, 0);
    end
    // single tap: 1.0 x coefficient
    op(0, 29'h03C00000, 29'h07800400);
    send(17'h07800, 17'h0F400, 1);
    expect_out(29'h0BE00000, 1, 6);
    wait_idle();
    // three-tap burst
    op(0, 29'h02000001, 29'h00000005);
    send(17'h04001, 17'h00005, 0);
    op(0, 29'h16000002, 29'h00400003);
    op(1, 29'h02000004, 29'h16400001);
    send(17'h1C002, 17'h00803, 0);
    op(0, 29'h10400000, 29'h10000010);
    op(1, 29'h18400005, 29'h00400010);
    send(17'h10800, 17'h10010, 1);
    expect_out(29'h18800015, 3, 11);
    wait_idle();
    // output backpressure
    out_ready = 0;
    op(0, 29'h16000002, 29'h00400003);
    send(17'h1C002, 17'h00803, 1);
    expect_out(29'h16400001, 1, 6);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_seen", out_valid, 1);
    repeat (7) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_tap_cnt", tap_cnt, 0);
    // reset in the second ADD_WAIT cycle
    op(0, 29'h02000001, 29'h00000005);
    send(17'h04001, 17'h00005, 0);
    op(0, 29'h16000002, 29'h00400003);
    op(1, 29'h02000004, 29'h16400001);
    send(17'h1C002, 17'h00803, 0);
    k = acc_cyc;
    n = 0;
    while (cyc != k + 8 && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_clk_en", alu_clk_en, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_clk_en", alu_clk_en, 0);
    chk("post_rst_tap_cnt", tap_cnt, 0);
    chk("post_rst_out_valid", out_valid, 0);
    op(0, 29'h10400000, 29'h10000010);
    send(17'h10800, 17'h10010, 1);
    expect_out(29'h00400010, 1, 6);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("opq_empty", opq.size(), 0);
    chk("oq_empty", oq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
